// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter and transaction sequencer sharing one spi_master among
// NUM_REQ clients. All outputs are registered.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// IDLE        | arbitrate; latch winner's grant, mode, divider and TX word
// SETUP       | one cycle for the master's sclk idle level to settle
// GO          | m_go high for exactly this cycle
// WAIT_BUSY   | wait for m_busy rise, bounded by BUSY_TIMEOUT cycles
// XFER        | wait for m_busy fall
// DRAIN       | one cycle, then capture m_datao into rsp_data
// RESP        | rsp_valid = gnt, rsp_err = timeout flag; release grant
module spi_master_arbiter #(
    parameter int NUM_REQ           = 4,
    parameter int DATA_WIDTH        = 8,
    parameter int CLK_DIVIDER_WIDTH = 4,
    parameter int BUSY_TIMEOUT      = 15
) (
    input  logic                                 clk,
    input  logic                                 resetb,
    input  logic [NUM_REQ-1:0]                   req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]        req_data,
    input  logic [NUM_REQ-1:0]                   req_cpol,
    input  logic [NUM_REQ-1:0]                   req_cpha,
    input  logic [NUM_REQ*CLK_DIVIDER_WIDTH-1:0] req_clk_divider,
    output logic [NUM_REQ-1:0]                   gnt,
    output logic [NUM_REQ-1:0]                   rsp_valid,
    output logic [DATA_WIDTH-1:0]                rsp_data,
    output logic                                 rsp_err,
    output logic [NUM_REQ-1:0]                   ss_sel,
    output logic                                 m_go,
    output logic [DATA_WIDTH-1:0]                m_datai,
    output logic                                 m_cpol,
    output logic                                 m_cpha,
    output logic [CLK_DIVIDER_WIDTH-1:0]         m_clk_divider,
    input  logic                                 m_busy,
    input  logic [DATA_WIDTH-1:0]                m_datao
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_GO, S_WAIT_BUSY, S_XFER, S_DRAIN, S_RESP
    } state_t;

    state_t state, next_state;

    logic [IW-1:0]                last, last_d, win_idx;
    logic                         win_vld;
    logic [NUM_REQ-1:0]           win_onehot;
    logic [DATA_WIDTH-1:0]        win_data;
    logic                         win_cpol, win_cpha;
    logic [CLK_DIVIDER_WIDTH-1:0] win_div;
    logic [CW-1:0]                busy_cnt, busy_cnt_d;
    logic                         timeout;

    logic [NUM_REQ-1:0]           gnt_d, rsp_valid_d;
    logic [DATA_WIDTH-1:0]        rsp_data_d, m_datai_d;
    logic                         rsp_err_d, m_go_d, m_cpol_d, m_cpha_d;
    logic [CLK_DIVIDER_WIDTH-1:0] m_clk_divider_d;

    // Search upward from last+1 with wrap-around; first set request wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = last;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!win_vld && req[i] && (i == (int'(last) + k) % NUM_REQ)) begin
                    win_vld = 1'b1;
                    win_idx = IW'(i);
                end
            end
        end
    end

    always_comb begin
        win_onehot = '0;
        win_data   = '0;
        win_cpol   = 1'b0;
        win_cpha   = 1'b0;
        win_div    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IW'(i)) begin
                win_onehot[i] = 1'b1;
                win_data      = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                win_cpol      = req_cpol[i];
                win_cpha      = req_cpha[i];
                win_div       = req_clk_divider[i*CLK_DIVIDER_WIDTH +: CLK_DIVIDER_WIDTH];
            end
        end
    end

    assign timeout = (state == S_WAIT_BUSY) && !m_busy && (busy_cnt == '0);

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) state <= S_IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:      if (win_vld) next_state = S_SETUP;
            S_SETUP:     next_state = S_GO;
            S_GO:        next_state = S_WAIT_BUSY;
            S_WAIT_BUSY: if (m_busy) next_state = S_XFER;
                         else if (timeout) next_state = S_RESP;
            S_XFER:      if (!m_busy) next_state = S_DRAIN;
            S_DRAIN:     next_state = S_RESP;
            S_RESP:      next_state = S_IDLE;
            default:     next_state = S_IDLE;
        endcase
    end

    // Next values for the registered outputs; rsp_err doubles as the error flag.
    always_comb begin
        gnt_d           = gnt;
        last_d          = last;
        m_datai_d       = m_datai;
        m_cpol_d        = m_cpol;
        m_cpha_d        = m_cpha;
        m_clk_divider_d = m_clk_divider;
        rsp_data_d      = rsp_data;
        rsp_err_d       = rsp_err;
        busy_cnt_d      = '0;
        m_go_d          = (next_state == S_GO);
        rsp_valid_d     = (next_state == S_RESP) ? gnt : '0;
        case (state)
            S_IDLE: begin
                if (win_vld) begin
                    gnt_d           = win_onehot;
                    last_d          = win_idx;
                    m_datai_d       = win_data;
                    m_cpol_d        = win_cpol;
                    m_cpha_d        = win_cpha;
                    m_clk_divider_d = win_div;
                end
            end
            S_GO:        busy_cnt_d = CW'(BUSY_TIMEOUT - 1);
            S_WAIT_BUSY: begin
                if (timeout)                rsp_err_d  = 1'b1;
                else if (busy_cnt != '0)    busy_cnt_d = busy_cnt - 1'b1;
            end
            S_DRAIN:     rsp_data_d = m_datao;
            S_RESP: begin
                gnt_d     = '0;
                rsp_err_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            gnt           <= '0;
            ss_sel        <= '0;
            rsp_valid     <= '0;
            rsp_data      <= '0;
            rsp_err       <= 1'b0;
            m_go          <= 1'b0;
            m_datai       <= '0;
            m_cpol        <= 1'b0;
            m_cpha        <= 1'b0;
            m_clk_divider <= '0;
            last          <= IW'(NUM_REQ - 1);
            busy_cnt      <= '0;
        end else begin
            gnt           <= gnt_d;
            ss_sel        <= gnt_d;
            rsp_valid     <= rsp_valid_d;
            rsp_data      <= rsp_data_d;
            rsp_err       <= rsp_err_d;
            m_go          <= m_go_d;
            m_datai       <= m_datai_d;
            m_cpol        <= m_cpol_d;
            m_cpha        <= m_cpha_d;
            m_clk_divider <= m_clk_divider_d;
            last          <= last_d;
            busy_cnt      <= busy_cnt_d;
        end
    end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Randomized bench for spi_master_arbiter: a loopback spi_master stand-in and a
// transaction-level round-robin reference model.
module tb_spi_master_arbiter;
    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int CDW = 4;
    localparam int TO  = 15;

    logic           clk = 1'b0;
    logic           resetb;
    logic [N-1:0]   req, req_cpol, req_cpha;
    logic [N*DW-1:0]  req_data;
    logic [N*CDW-1:0] req_clk_divider;
    logic [N-1:0]   gnt, rsp_valid, ss_sel;
    logic [DW-1:0]  rsp_data, m_datai, m_datao;
    logic           rsp_err, m_go, m_cpol, m_cpha, m_busy;
    logic [CDW-1:0] m_clk_divider;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0]  cfg_data [N];
    logic           cfg_cpol [N];
    logic           cfg_cpha [N];
    logic [CDW-1:0] cfg_div  [N];
    int             model_last = N - 1;
    logic [DW-1:0]  exp_rsp = '0;

    spi_master_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .CLK_DIVIDER_WIDTH(CDW), .BUSY_TIMEOUT(TO)
    ) dut (
        .clk(clk), .resetb(resetb), .req(req), .req_data(req_data),
        .req_cpol(req_cpol), .req_cpha(req_cpha), .req_clk_divider(req_clk_divider),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .ss_sel(ss_sel), .m_go(m_go), .m_datai(m_datai), .m_cpol(m_cpol),
        .m_cpha(m_cpha), .m_clk_divider(m_clk_divider), .m_busy(m_busy),
        .m_datao(m_datao)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_cfg();
        for (int i = 0; i < N; i++) begin
            req_data[i*DW +: DW]          = cfg_data[i];
            req_cpol[i]                   = cfg_cpol[i];
            req_cpha[i]                   = cfg_cpha[i];
            req_clk_divider[i*CDW +: CDW] = cfg_div[i];
        end
    endtask

    task automatic rand_cfg();
        for (int i = 0; i < N; i++) begin
            cfg_data[i] = DW'($urandom);
            cfg_cpol[i] = 1'($urandom_range(0, 1));
            cfg_cpha[i] = 1'($urandom_range(0, 1));
            cfg_div[i]  = CDW'($urandom);
        end
        drive_cfg();
    endtask

    // Reference: first requester above the previous winner, wrapping around.
    function automatic int pick(input logic [N-1:0] r, input int last);
        logic [N-1:0] s;
        for (int k = 1; k <= N; k++) begin
            s = r >> ((last + k) % N);
            if (s[0]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_gnt"},  32'(gnt), 0);
        chk({tag, "_ss"},   32'(ss_sel), 0);
        chk({tag, "_rv"},   32'(rsp_valid), 0);
        chk({tag, "_rd"},   32'(rsp_data), 0);
        chk({tag, "_re"},   32'(rsp_err), 0);
        chk({tag, "_go"},   32'(m_go), 0);
        chk({tag, "_di"},   32'(m_datai), 0);
        chk({tag, "_cpol"}, 32'(m_cpol), 0);
        chk({tag, "_cpha"}, 32'(m_cpha), 0);
        chk({tag, "_div"},  32'(m_clk_divider), 0);
    endtask

    task automatic run_txn(input bit stuck, input bit drop_setup, input bit keep_req);
        int w, n, d, len;
        logic [DW-1:0]  sent;
        logic           cp, ch;
        logic [CDW-1:0] dv;
        w = pick(req, model_last);
        if (w < 0) return;
        sent = cfg_data[w]; cp = cfg_cpol[w]; ch = cfg_cpha[w]; dv = cfg_div[w];
        n = 0;
        do begin @(posedge clk); #1; n++; end while (gnt == '0 && n < 8);
        chk("gnt_lat", 32'(n), 1);
        chk("gnt", 32'(gnt), 32'(1) << w);
        chk("ss_sel", 32'(ss_sel), 32'(1) << w);
        chk("m_datai", 32'(m_datai), 32'(sent));
        chk("m_cpol", 32'(m_cpol), 32'(cp));
        chk("m_cpha", 32'(m_cpha), 32'(ch));
        chk("m_div", 32'(m_clk_divider), 32'(dv));
        chk("go_setup", 32'(m_go), 0);
        if (gnt == '0) return;
        model_last = w;
        // Scramble requester inputs: the latched values must not follow them.
        req_data = {N{DW'($urandom)}}; req_cpol = ~req_cpol; req_cpha = ~req_cpha;
        req_clk_divider = ~req_clk_divider;
        if (drop_setup) req &= ~(N'(1) << w);
        @(posedge clk); #1;
        chk("go", 32'(m_go), 1);
        chk("datai_hold", 32'(m_datai), 32'(sent));
        chk("cpol_hold", 32'(m_cpol), 32'(cp));
        chk("div_hold", 32'(m_clk_divider), 32'(dv));
        drive_cfg();
        @(posedge clk); #1;
        chk("go_pulse", 32'(m_go), 0);
        if (stuck) begin
            repeat (TO - 1) @(posedge clk);
            #1;
            chk("to_early", 32'(rsp_valid), 0);
            @(posedge clk); #1;
            chk("to_valid", 32'(rsp_valid), 32'(1) << w);
            chk("to_err", 32'(rsp_err), 1);
            chk("to_data", 32'(rsp_data), 32'(exp_rsp));
        end else begin
            d = $urandom_range(0, 3);
            len = $urandom_range(1, 6);
            repeat (d) begin @(posedge clk); #1; end
            m_busy = 1'b1; m_datao = DW'($urandom);
            repeat (len) begin @(posedge clk); #1; end
            m_busy = 1'b0; m_datao = sent;
            @(posedge clk); #1;
            chk("drain_rv", 32'(rsp_valid), 0);
            @(posedge clk); #1;
            chk("rsp_valid", 32'(rsp_valid), 32'(1) << w);
            chk("rsp_data", 32'(rsp_data), 32'(sent));
            chk("rsp_err", 32'(rsp_err), 0);
            exp_rsp = sent;
            m_datao = DW'($urandom);
        end
        if (!keep_req) req &= ~(N'(1) << w);
        @(posedge clk); #1;
        chk("idle_rv", 32'(rsp_valid), 0);
        chk("idle_gnt", 32'(gnt), 0);
        chk("idle_err", 32'(rsp_err), 0);
        chk("rsp_hold", 32'(rsp_data), 32'(exp_rsp));
    endtask

    initial begin
        resetb = 1'b0; req = '0; m_busy = 1'b0; m_datao = '0;
        rand_cfg();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        resetb = 1'b1;

        // All four modes, simultaneous requests
        cfg_data[0] = 8'h00; cfg_cpol[0] = 0; cfg_cpha[0] = 0;
        cfg_data[1] = 8'hA5; cfg_cpol[1] = 0; cfg_cpha[1] = 1;
        cfg_data[2] = 8'h3C; cfg_cpol[2] = 1; cfg_cpha[2] = 0;
        cfg_data[3] = 8'hFF; cfg_cpol[3] = 1; cfg_cpha[3] = 1;
        drive_cfg();
        req = 4'b1111;
        for (int t = 0; t < N; t++) run_txn(1'b0, 1'b0, 1'b0);

        // Single requester 2, 0xA5, mode 0, divider 4
        cfg_data[2] = 8'hA5; cfg_cpol[2] = 0; cfg_cpha[2] = 0; cfg_div[2] = 4'd4;
        drive_cfg();
        req = 4'b0100;
        run_txn(1'b0, 1'b0, 1'b0);

        // Request withdrawn during SETUP
        req = 4'b0001;
        run_txn(1'b0, 1'b1, 1'b0);

        // Busy never rises
        req = 4'b0010;
        run_txn(1'b1, 1'b0, 1'b0);

        // Reset in the middle of XFER
        cfg_data[2] = 8'h5A; cfg_cpol[2] = 1; cfg_cpha[2] = 1; cfg_div[2] = 4'd9;
        drive_cfg();
        req = 4'b0100;
        begin
            int n = 0;
            do begin @(posedge clk); #1; n++; end while (gnt == '0 && n < 8);
            chk("mid_gnt", 32'(gnt), 32'b0100);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        m_busy = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        resetb = 1'b0;
        #1;
        check_reset_outputs("mid");
        m_busy = 1'b0; req = 4'b0101; model_last = N - 1; exp_rsp = '0;
        @(posedge clk); #1;
        chk("mid_held", 32'(gnt), 0);
        resetb = 1'b1;
        run_txn(1'b0, 1'b0, 1'b0);

        // Fairness: 1 and 3 requesting continuously
        req = 4'b1010;
        for (int t = 0; t < 6; t++) run_txn(1'b0, 1'b0, 1'b1);
        req = '0;
        @(posedge clk); #1;

        // Randomized traffic
        for (int t = 0; t < 24; t++) begin
            rand_cfg();
            req = N'($urandom_range(1, (1 << N) - 1));
            run_txn($urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
